receptor_clk_lento: RTL
=======================

Name: receptor_clk_lento

Overview:
- Fast-domain receiver for the slow square wave `clk_lento` produced by the ripple divider.
- Synchronizes `clk_lento` into `clk` and emits one-cycle ticks on its rising edges.
- Holds a sticky event flag with acknowledge handshake, counts events, measures the slow period in `clk` cycles, and flags a stalled divider.
- Consumers: conveyor control FSMs that need a clean, `clk`-synchronous slow timebase instead of a derived clock.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `clk_lento` (min 2).
- CNT_W, 26, width of period counter and `periodo` output.
- TIMEOUT, 50000000, `clk` cycles without a rising edge before `parado` asserts. Constraint: TIMEOUT < 2^CNT_W-1.
- EVT_W, 8, width of event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high; sampled only on posedge `clk`.
- clk_lento  in  1  asynchronous slow square wave from the divider.
- ack  in  1  consumer acknowledge; clears `pend`.
- tick  out  1  one-cycle pulse per synchronized rising edge of `clk_lento`.
- pend  out  1  sticky event-pending flag.
- ovr  out  1  sticky overrun: an edge arrived while `pend`=1 and no `ack`.
- evt_cnt  out  EVT_W  count of rising edges, modulo 2^EVT_W.
- periodo  out  CNT_W  last measured rise-to-rise interval in `clk` cycles.
- periodo_valid  out  1  `periodo` holds a valid measurement.
- parado  out  1  no rising edge seen for TIMEOUT cycles.

Behaviour:
- Reset (`rst`=1 at posedge `clk`): the following are all cleared to 0:
  - all outputs;
  - synchronizer chain and edge-history flop;
  - counter `cnt`;
  - priming counter.
  - State goes to ESPERA.
  - Reset mid-measurement discards everything; there is no partial state retention.
- Synchronizer: `clk_lento` passes through SYNC_STAGES flops; `s` is the last stage, `s_d` is `s` delayed one cycle. `rise = s & ~s_d`.
- Priming: `rise` is ignored for the first SYNC_STAGES+1 cycles after reset release. If `clk_lento` is already high at reset release, no tick is produced.
- Latency: if `clk_lento` is high and stable before `clk` edge k, then with SYNC_STAGES=2, `tick`=1 between edges k+2 and k+3. `tick` is registered and is never high for two consecutive cycles.
- Handshake:
  - A rise sets `pend` at the same edge as `tick`.
  - `ack`=1 with no rise clears `pend` next edge.
  - Rise and `ack` in the same cycle: `pend` stays 1 (set wins) and `ovr` is not set.
  - Rise while `pend`=1 and `ack`=0: `ovr` <= 1, held until `rst`.
  - `ack` while `pend`=0: no effect.
- `evt_cnt`: +1 on every accepted rise, in every state. Wraps from 2^EVT_W-1 to 0.
- `cnt`:
  - On a rise: `cnt` <= 1.
  - Otherwise: +1 per cycle, holding at TIMEOUT (never exceeds it).
- States:
  - ESPERA:
    - rise -> MEDINDO, no period update;
    - `cnt`==TIMEOUT with no rise -> PARADO.
  - MEDINDO:
    - rise -> `periodo` <= `cnt` (current value, before reload), `periodo_valid` <= 1, stay;
    - `cnt`==TIMEOUT with no rise -> PARADO, `parado` <= 1, `periodo_valid` <= 0, `periodo` holds its last value.
  - PARADO:
    - rise -> ESPERA, `parado` <= 0; the stalled interval is never reported;
    - a valid `periodo` needs the next two rises.
- For a periodic input of P `clk` cycles, `periodo`=P exactly. Duty cycle is irrelevant.
- `parado` and `tick` can never be 1 in the same cycle.

Test Plan:
- CNT_W=8, TIMEOUT=100, EVT_W=4; reset; `clk_lento` period 20 (10 high/10 low) -> one `tick` per period; after 1st tick `periodo_valid`=0; after 2nd tick `periodo`=20, `periodo_valid`=1; `periodo` stays 20 thereafter.
- Latency: `clk_lento` 0->1 before edge k -> `tick`=1 only between edges k+2 and k+3; `pend`=1 from edge k+2.
- Handshake: two rises with no `ack` -> `ovr`=1; `ack` coincident with a rise -> `pend` stays 1, `ovr` stays 0; 16 rises -> `evt_cnt` back to 0.
- Stall: after valid measurement, hold `clk_lento` low -> `parado`=1 and `periodo_valid`=0 exactly 100 cycles after last rise, `periodo`=20 retained; resume period 30 -> `parado`=0 at first rise, `periodo`=30 and `periodo_valid`=1 only at third rise after resume.
- Reset mid-operation with `clk_lento` held high -> all outputs 0 the cycle after `rst`; no `tick` after release while high; first `tick` follows the next real low->high transition; `periodo_valid`=0 until two further rises.

Source files
------------

// File: rtl/receptor_clk_lento.sv
// Fast-domain receiver for the divider's slow square wave: synchronizes it, emits
// one-cycle rise ticks, keeps a pending/overrun handshake, counts events and measures the period.
module receptor_clk_lento #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 26,
  parameter int TIMEOUT     = 50000000,
  parameter int EVT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_lento,
  input  logic             ack,
  output logic             tick,
  output logic             pend,
  output logic             ovr,
  output logic [EVT_W-1:0] evt_cnt,
  output logic [CNT_W-1:0] periodo,
  output logic             periodo_valid,
  output logic             parado
);

  localparam int PRIME = SYNC_STAGES + 1;
  localparam int PW    = $clog2(PRIME + 1);
  localparam logic [PW-1:0]    PRIME_V = PW'(PRIME);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  localparam logic [1:0] ESPERA  = 2'd0;
  localparam logic [1:0] MEDINDO = 2'd1;
  localparam logic [1:0] PARADO  = 2'd2;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise, acc, at_tmo;
  logic [PW-1:0]          prime;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             state;

  assign s      = sync[SYNC_STAGES-1];
  assign rise   = s & ~s_d;
  // The chain is cleared by reset, so a level that was already high looks like a
  // fresh rise; priming masks it until the chain reflects the real input.
  assign acc    = rise & (prime == PRIME_V);
  assign at_tmo = (cnt == TMO);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= '0;
      s_d           <= 1'b0;
      prime         <= '0;
      cnt           <= '0;
      state         <= ESPERA;
      tick          <= 1'b0;
      pend          <= 1'b0;
      ovr           <= 1'b0;
      evt_cnt       <= '0;
      periodo       <= '0;
      periodo_valid <= 1'b0;
      parado        <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clk_lento};
      s_d  <= s;
      if (prime != PRIME_V) prime <= prime + PW'(1);
      tick <= acc;

      if (acc) begin
        pend    <= 1'b1;
        if (pend && !ack) ovr <= 1'b1;
        evt_cnt <= evt_cnt + EVT_W'(1);
        cnt     <= CNT_W'(1);
      end else begin
        if (ack) pend <= 1'b0;
        if (!at_tmo) cnt <= cnt + CNT_W'(1);
      end

      case (state)
        ESPERA: begin
          if (acc) state <= MEDINDO;
          else if (at_tmo) begin
            state  <= PARADO;
            parado <= 1'b1;
          end
        end
        MEDINDO: begin
          if (acc) begin
            periodo       <= cnt;
            periodo_valid <= 1'b1;
          end else if (at_tmo) begin
            state         <= PARADO;
            parado        <= 1'b1;
            periodo_valid <= 1'b0;
          end
        end
        PARADO: begin
          // The stalled interval is meaningless, so restart from a fresh reference rise.
          if (acc) begin
            state  <= ESPERA;
            parado <= 1'b0;
          end
        end
        default: state <= ESPERA;
      endcase
    end
  end

endmodule
